// File: rtl/mem_access_ctrl_if.sv
// Client and bitcell-array signal bundle for mem_access_ctrl.
// Modports: slave = controller, master = client, array = bitcell array.
interface mem_access_ctrl_if #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ROWS-1:0]   arr_sel;
    logic              arr_rw;
    logic [DATA_W-1:0] arr_in;
    logic [DATA_W-1:0] arr_out;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, arr_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output arr_sel, arr_rw, arr_in
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport array (
        input  arr_sel, arr_rw, arr_in,
        output arr_out
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Setup/strobe/hold access sequencer for a bitcell_nor memory array.
// Ports: clk, rst_n (async active-low), bus (mem_access_ctrl_if.slave).
module mem_access_ctrl #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // One extra bit so ROWS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] ROWS_W = (ADDR_W + 1)'(ROWS);

    logic [1:0]        state;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic              in_range;

    assign in_range = {1'b0, bus.req_addr} < ROWS_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            lat_rw        <= 1'b0;
            lat_addr      <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.arr_sel   <= '0;
            bus.arr_rw    <= 1'b0;
            bus.arr_in    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_rw        <= bus.req_rw;
                        lat_addr      <= bus.req_addr;
                        bus.req_ready <= 1'b0;
                        if (in_range) begin
                            // rw/in settle one cycle before sel rises.
                            bus.arr_rw <= bus.req_rw;
                            bus.arr_in <= bus.req_rw ? bus.req_wdata : '0;
                            state      <= S_SETUP;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    bus.arr_sel <= ROWS'(1) << lat_addr;
                    state       <= S_ACCESS;
                end
                S_ACCESS: begin
                    // rw/in stay put through RESP as the hold phase.
                    bus.arr_sel   <= '0;
                    bus.rsp_rdata <= lat_rw ? '0 : bus.arr_out;
                    bus.rsp_valid <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.arr_rw    <= 1'b0;
                        bus.arr_in    <= '0;
                        bus.req_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with behavioural bitcell arrays.
// DUT0: ROWS=4, DUT1: ROWS=3 (out-of-range addressing).
module tb_mem_access_ctrl;
    logic clk;
    logic rst_n;
    logic dsel;
    logic req_valid, req_rw, rsp_ready;
    logic [1:0] req_addr;
    logic [3:0] req_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_ctrl_if #(.ROWS(4), .ADDR_W(2), .DATA_W(4)) b0 ();
    mem_access_ctrl_if #(.ROWS(3), .ADDR_W(2), .DATA_W(4)) b1 ();

    mem_access_ctrl #(.ROWS(4), .ADDR_W(2), .DATA_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    mem_access_ctrl #(.ROWS(3), .ADDR_W(2), .DATA_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    assign b0.req_valid = req_valid & ~dsel;
    assign b1.req_valid = req_valid & dsel;
    assign b0.req_rw    = req_rw;
    assign b1.req_rw    = req_rw;
    assign b0.req_addr  = req_addr;
    assign b1.req_addr  = req_addr;
    assign b0.req_wdata = req_wdata;
    assign b1.req_wdata = req_wdata;
    assign b0.rsp_ready = rsp_ready;
    assign b1.rsp_ready = rsp_ready;

    // Behavioural arrays: write on the edge while sel && rw, wired-OR read.
    logic [3:0] mem0 [4];
    logic [3:0] mem1 [3];

    always_comb begin
        b0.arr_out = '0;
        for (int r = 0; r < 4; r++)
            if (b0.arr_sel[r]) b0.arr_out = b0.arr_out | mem0[r];
    end

    always_comb begin
        b1.arr_out = '0;
        for (int r = 0; r < 3; r++)
            if (b1.arr_sel[r]) b1.arr_out = b1.arr_out | mem1[r];
    end

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++)
            if (b0.arr_sel[r] && b0.arr_rw) mem0[r] <= b0.arr_in;
        for (int r = 0; r < 3; r++)
            if (b1.arr_sel[r] && b1.arr_rw) mem1[r] <= b1.arr_in;
    end

    logic [3:0] o_sel, o_in, o_rdata;
    logic       o_rw, o_ready, o_valid, o_err;

    assign o_sel   = dsel ? {1'b0, b1.arr_sel} : b0.arr_sel;
    assign o_rw    = dsel ? b1.arr_rw    : b0.arr_rw;
    assign o_in    = dsel ? b1.arr_in    : b0.arr_in;
    assign o_ready = dsel ? b1.req_ready : b0.req_ready;
    assign o_valid = dsel ? b1.rsp_valid : b0.rsp_valid;
    assign o_rdata = dsel ? b1.rsp_rdata : b0.rsp_rdata;
    assign o_err   = dsel ? b1.rsp_err   : b0.rsp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // sel may only be one-hot, and rw/in must not move while it is high.
    logic [3:0] p0_in, p1_in;
    logic       p0_rw, p1_rw;

    always @(negedge clk) begin
        if (rst_n && b0.arr_sel != 0) begin
            chk("dut0_sel_onehot", 32'($onehot(b0.arr_sel)), 1);
            chk("dut0_rw_stable", b0.arr_rw, p0_rw);
            chk("dut0_in_stable", b0.arr_in, p0_in);
        end
        if (rst_n && b1.arr_sel != 0) begin
            chk("dut1_sel_onehot", 32'($onehot(b1.arr_sel)), 1);
            chk("dut1_rw_stable", b1.arr_rw, p1_rw);
            chk("dut1_in_stable", b1.arr_in, p1_in);
        end
        p0_rw = b0.arr_rw;
        p0_in = b0.arr_in;
        p1_rw = b1.arr_rw;
        p1_in = b1.arr_in;
    end

    logic [3:0] tr_sel [8];
    logic [3:0] tr_in  [8];
    logic       tr_rw  [8];

    // Cycle index 1 is the cycle after the handshake edge.
    task automatic access(input logic rw, input logic [1:0] a,
                          input logic [3:0] wd, input int hold,
                          output logic [3:0] rd, output logic er,
                          output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_req", o_ready, 1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 4'($urandom);
        for (lat = 1; lat < 8; lat++) begin
            tr_sel[lat] = o_sel;
            tr_rw[lat]  = o_rw;
            tr_in[lat]  = o_in;
            if (o_valid) break;
            @(posedge clk);
            #1;
        end
        rd = o_rdata;
        er = o_err;
        chk("ready_low_in_resp", o_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_rdata", o_rdata, rd);
            chk("hold_ready", o_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_valid", o_valid, 0);
        chk("idle_rdata", o_rdata, 0);
        chk("idle_err", o_err, 0);
        chk("idle_ready", o_ready, 1);
        chk("idle_arr_rw", o_rw, 0);
        chk("idle_arr_in", o_in, 0);
    endtask

    typedef struct {
        logic       d;
        logic       rw;
        logic [1:0] a;
        logic [3:0] wd;
        logic [3:0] rd;
        logic       er;
    } vec_t;

    vec_t v [18];

    initial begin
        logic [3:0] rd;
        logic       er;
        int         lat;

        v[0]  = '{1'b0, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0};
        v[1]  = '{1'b0, 1'b0, 2'd2, 4'hF, 4'hA, 1'b0};
        v[2]  = '{1'b0, 1'b1, 2'd0, 4'h1, 4'h0, 1'b0};
        v[3]  = '{1'b0, 1'b1, 2'd1, 4'h2, 4'h0, 1'b0};
        v[4]  = '{1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 1'b0};
        v[5]  = '{1'b0, 1'b1, 2'd3, 4'h8, 4'h0, 1'b0};
        v[6]  = '{1'b0, 1'b0, 2'd3, 4'h5, 4'h8, 1'b0};
        v[7]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h1, 1'b0};
        v[8]  = '{1'b0, 1'b0, 2'd2, 4'h0, 4'h4, 1'b0};
        v[9]  = '{1'b0, 1'b0, 2'd1, 4'h0, 4'h2, 1'b0};
        v[10] = '{1'b1, 1'b1, 2'd0, 4'h3, 4'h0, 1'b0};
        v[11] = '{1'b1, 1'b1, 2'd1, 4'h6, 4'h0, 1'b0};
        v[12] = '{1'b1, 1'b1, 2'd2, 4'hC, 4'h0, 1'b0};
        v[13] = '{1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b1};
        v[14] = '{1'b1, 1'b0, 2'd3, 4'h0, 4'h0, 1'b1};
        v[15] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h3, 1'b0};
        v[16] = '{1'b1, 1'b0, 2'd1, 4'h0, 4'h6, 1'b0};
        v[17] = '{1'b1, 1'b0, 2'd2, 4'h0, 4'hC, 1'b0};

        for (int r = 0; r < 4; r++) mem0[r] = '0;
        for (int r = 0; r < 3; r++) mem1[r] = '0;
        dsel      = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;

        // Reset lands before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            dsel = 1'(d);
            #0;
            chk("rst_ready", o_ready, 1);
            chk("rst_valid", o_valid, 0);
            chk("rst_err", o_err, 0);
            chk("rst_rdata", o_rdata, 0);
            chk("rst_sel", o_sel, 0);
            chk("rst_rw", o_rw, 0);
            chk("rst_in", o_in, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        dsel = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", o_ready, 1);

        for (int i = 0; i < 18; i++) begin
            dsel = v[i].d;
            access(v[i].rw, v[i].a, v[i].wd, 0, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_err", i), er, v[i].er);
            chk($sformatf("v%0d_lat", i), lat, v[i].er ? 1 : 3);
            chk($sformatf("v%0d_setup_sel", i), tr_sel[1], 0);
            if (!v[i].er) begin
                chk($sformatf("v%0d_acc_sel", i), tr_sel[2],
                    4'(1) << v[i].a);
                chk($sformatf("v%0d_resp_sel", i), tr_sel[3], 0);
                for (int c = 1; c <= 3; c++) begin
                    chk($sformatf("v%0d_rw_c%0d", i, c), tr_rw[c], v[i].rw);
                    chk($sformatf("v%0d_in_c%0d", i, c), tr_in[c],
                        v[i].rw ? v[i].wd : 4'h0);
                end
            end
        end

        // Backpressure on a read of 0x5.
        dsel = 1'b0;
        access(1'b1, 2'd1, 4'h5, 0, rd, er, lat);
        access(1'b0, 2'd1, 4'h0, 5, rd, er, lat);
        chk("bp_rdata", rd, 4'h5);
        chk("bp_err", er, 0);

        // Reset in the middle of the ACCESS cycle of a write to row 1.
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 2'd1;
        req_wdata = 4'h9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_sel_before", o_sel, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sel", o_sel, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_ready", o_ready, 1);
        chk("abort_rw", o_rw, 0);
        chk("abort_in", o_in, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", o_valid, 0);
        end
        access(1'b0, 2'd0, 4'h0, 0, rd, er, lat);
        chk("abort_row0_rdata", rd, 4'h1);
        chk("abort_row0_lat", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Synchronous access controller that sits between a request/response client and a bitcell memory array built from `bitcell_nor` cells. It drives the array's per-row `sel`, shared `rw` and per-column `in` lines, and captures the wired-OR column outputs. Each access follows a fixed setup/strobe/hold sequence, so no cell ever sees `sel` high while `rw` or `in` is changing. It is the writer/reader that the bitcell array expects on its other side.

## Interface
- `ROWS`, default 4: number of words (rows) in the array; any value from 1 to 2^ADDR_W is legal.
- `ADDR_W`, default 2: request address width.
- `DATA_W`, default 4: word width (columns).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: the client presents a request.
- `req_ready` output 1: the controller can accept a request.
- `req_rw` input 1: 1 = write, 0 = read (same polarity as the cell `rw`).
- `req_addr` input ADDR_W: row index.
- `req_wdata` input DATA_W: write data.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: the client accepts the response.
- `rsp_rdata` output DATA_W: read data; 0 for writes and errors.
- `rsp_err` output 1: the address was out of range (`req_addr >= ROWS`).
- `arr_sel` output ROWS: one-hot row select, all-zero when idle.
- `arr_rw` output 1: array read/write line.
- `arr_in` output DATA_W: array column write data.
- `arr_out` input DATA_W: OR of all row outputs. Unselected rows contribute 0.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - `req_ready`=1; `arr_sel`=0, `arr_rw`=0, `arr_in`=0.
  - On `req_valid && req_ready`: latch rw, addr and wdata.
  - If addr < ROWS, go to SETUP. Otherwise go to RESP with `rsp_err`=1 and `rsp_rdata`=0; the array is not touched.
- SETUP, one cycle:
  - `arr_rw` = latched rw.
  - `arr_in` = wdata for a write, 0 for a read.
  - `arr_sel` = 0.
- ACCESS, one cycle:
  - `arr_sel` has exactly bit[addr] set. `arr_rw` and `arr_in` are unchanged.
- Leaving ACCESS, at the same edge:
  - Sample `arr_out` into `rsp_rdata` if the access is a read; otherwise load 0.
  - `arr_sel` returns to 0.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable.
  - `arr_rw` and `arr_in` are held at their access values, giving at least one hold cycle after `sel` falls.
  - On `rsp_ready`: go to IDLE; `rsp_valid`, `rsp_err` and `rsp_rdata` clear to 0; array lines go to their idle values.
- `req_ready` is 0 in every state except IDLE. Requests are never queued.
- Invariant: whenever any `arr_sel` bit is 1, `arr_rw` and `arr_in` hold the values they had on the previous cycle.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_err`=0; `rsp_rdata`=0; `arr_sel`=0; `arr_rw`=0; `arr_in`=0.
- Reset during SETUP/ACCESS/RESP aborts the access and no response is issued. A write aborted while `sel` was high leaves that row's content undefined; other rows are unaffected.
- Latency, counting the handshake edge as E0:
  - SETUP after E0.
  - ACCESS after E1.
  - RESP after E2, so `rsp_valid` is seen high in the cycle after E2.
  - Read data is sampled at E2.
  - Error responses: RESP directly after E0.
- Throughput: with `rsp_ready` tied high, one access every 4 cycles (IDLE, SETUP, ACCESS, RESP).
- `rsp_valid` may stay high indefinitely under backpressure. Outputs are held and the array is idle except for the held `arr_rw`/`arr_in`.
- `req_*` inputs are don't-care outside the handshake cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle → all outputs take their reset values without waiting for a clock edge; `req_ready`=1 after release.
- **Write then read** (ROWS=4, DATA_W=4), write addr 2 data 0xA, then read addr 2:
  - Write: `arr_sel`=0b0100 for exactly one cycle, with `arr_rw`=1 and `arr_in`=0xA stable from the cycle before `sel` rises until the cycle after it falls.
  - Read: `rsp_rdata`=0xA, `rsp_err`=0, `rsp_valid` 3 cycles after the handshake.
- **Row isolation:** write 0x1, 0x2, 0x4, 0x8 to rows 0 to 3, then read rows 3, 0, 2, 1 → data 0x8, 0x1, 0x4, 0x2. Every `arr_sel` value observed is one-hot or zero.
- **Out of range** (ROWS=3, ADDR_W=2): write addr 3 → `rsp_err`=1, `rsp_rdata`=0 one cycle after the handshake, `arr_sel` never nonzero. A subsequent read of rows 0 to 2 shows no corruption.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after a read of 0x5 → `rsp_valid`, `rsp_rdata`=0x5 and `req_ready`=0 stay stable. Raising `rsp_ready` returns to IDLE on the next edge.
- **Reset during ACCESS** of a write to row 1 → `arr_sel`=0 immediately and no `rsp_valid`. After reset, a read of row 0 returns its previously written value.
